register_file: RTL and testbench
================================

# register_file

Sixteen-entry, 16-bit register file sitting directly downstream of the instruction controller. It consumes the controller's select and enable strobes, drives the shared data bus and the ALU operand lines, and owns the architectural pointer registers: PC, SP, BA, RA and RES. PC and SP increment and decrement are implemented here as dedicated counter behaviour, not as ALU operations.

## Interface
Parameters:
- SP_INIT, 16'hFFFF, stack pointer value after reset.
- PC_INIT, 16'h0000, program counter value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  16  data bus into the register file.
- reg_src_sel  input  4  source register index (bus and ALU operand B).
- reg_dst_sel  input  4  destination register index (write target and ALU operand A).
- reg_in_en  input  1  full 16-bit write of `in` to reg_dst_sel.
- reg_up_en  input  1  write in[7:0] to the upper byte of reg_dst_sel.
- reg_lo_en  input  1  write in[7:0] to the lower byte of reg_dst_sel.
- reg_out_en  input  1  drive the reg_src_sel value onto `out`.
- reg_pc_inc  input  1  PC <= PC + 1.
- reg_sp_inc  input  1  SP <= SP + 1.
- reg_sp_dec  input  1  SP <= SP - 1.
- out  output  16  bus drive; 16'h0000 when reg_out_en = 0.
- src_out  output  16  continuous value of reg_src_sel (ALU operand B).
- dst_out  output  16  continuous value of reg_dst_sel (ALU operand A).

## Operation
- Register map:
  - R0 = zero register.
  - 1 = PC, 2 = SP, 3 = BA, 4 = RA, 15 = RES.
  - 5..14 = general purpose.
- R0 always reads 16'h0000. All writes and byte writes to R0 are discarded, so an idle select of 0 is harmless.
- Reads are combinational from stored state. There is no write-to-read bypass: a value written at edge N is visible after edge N.
- Write priority per edge, highest first:
  1. rst
  2. reg_in_en
  3. reg_up_en / reg_lo_en
  4. pointer inc/dec
- Byte writes:
  - reg_up_en alone: dst <= {in[7:0], dst[7:0]}.
  - reg_lo_en alone: dst <= {dst[15:8], in[7:0]}.
  - Both asserted: dst <= {in[7:0], in[7:0]}.
- PC:
  - reg_pc_inc adds 1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - A same-edge write to PC (reg_dst_sel = 1 with reg_in_en, up_en or lo_en) wins over the increment. The increment is dropped, not applied afterwards.
- SP:
  - inc/dec wrap modulo 2^16.
  - reg_sp_inc and reg_sp_dec together: SP unchanged.
  - A same-edge write to SP wins over inc/dec.
- Pointer inc/dec never affects any register other than PC/SP, regardless of reg_dst_sel.
- Reset values: PC = PC_INIT, SP = SP_INIT, all other registers 16'h0000.
- Reset output values: out = 16'h0000 (reg_out_en ignored only in the sense that it selects a zeroed register), src_out/dst_out show the reset contents of the selected registers.
- rst asserted mid-sequence overrides every strobe on that edge.

## Timing
- The controller changes strobes on the falling edge. This block samples them on the following rising edge, a half-cycle later.
- Write latency: 1 rising edge.
- Read latency: 0 (combinational). out, src_out and dst_out settle within the same half-cycle as the select changes.
- Fetch example: cycle 0 with sel = PC and reg_out_en puts PC on the bus. Cycle 1 pc_inc updates PC at the rising edge of cycle 1.
- JALR: a cycle-3 copy of PC into RA is followed by a cycle-4 write of the src register into PC. Each completes at its own rising edge, with no interaction.

## Configuration
- REG_FILE_DEBUG_EN defined:
  - Adds input dbg_sel [3:0] and output dbg_data [15:0], a combinational third read port for the display/monitor.
  - R0 reads 0 on this port as well.
- REG_FILE_DEBUG_EN undefined: both ports are absent; behaviour is otherwise identical.

## Structure
- Shared package tiny16_pkg holds:
  - register index constants REG_ZERO, REG_PC, REG_SP, REG_BA, REG_RA, REG_RES;
  - data width constant WORD_W = 16;
  - reset constants mirroring PC_INIT/SP_INIT.
- The controller uses the same constants.
- One sub-module, pointer_reg: a 16-bit register with load, inc and dec and a reset value parameter. It is instantiated for PC (dec tied low) and SP. General registers are a plain array.

## Test plan
- Reset: assert rst for 1 edge, then select each index. Required: PC = 0000, SP = FFFF, others 0000; out = 0000 with reg_out_en = 0.
- Byte loads: R5 gets lo_en with in = 00AB, then up_en with in = 00CD. Required: R5 = CDAB. Then reg_in_en with dst = 0 and in = 1234. Required: R0 still reads 0000.
- PC increment and override:
  - PC = FFFF, pc_inc → PC = 0000.
  - Same edge pc_inc plus reg_in_en with dst = PC and in = 0040 → PC = 0040.
- SP push/pop sequence: from reset, sp_dec → FFFE; sp_inc → FFFF; inc and dec together → FFFF; SP = 0000 with sp_dec → FFFF.
- Bus/ALU ports: R6 = 0007, R7 = 0003, src_sel = 7, dst_sel = 6, reg_out_en = 1. Required: out = 0003, src_out = 0003, dst_out = 0006's value 0007. Also write R6 and check the old value persists until the edge.
- Reset mid-operation: rst on the same edge as reg_in_en to BA and sp_dec. Required: BA = 0000, SP = FFFF. With REG_FILE_DEBUG_EN, dbg_sel = 3 reads 0000.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared tiny16 constants: register map, data width, pointer reset values,
// and the byte/word write merge used by the register file.
package tiny16_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] REG_ZERO = 4'd0;
    localparam logic [SEL_W-1:0] REG_PC   = 4'd1;
    localparam logic [SEL_W-1:0] REG_SP   = 4'd2;
    localparam logic [SEL_W-1:0] REG_BA   = 4'd3;
    localparam logic [SEL_W-1:0] REG_RA   = 4'd4;
    localparam logic [SEL_W-1:0] REG_RES  = 4'd15;

    localparam logic [WORD_W-1:0] PC_RESET = 16'h0000;
    localparam logic [WORD_W-1:0] SP_RESET = 16'hFFFF;

    typedef struct packed {
        logic full;
        logic up;
        logic lo;
    } wr_strb_t;

    // Full word beats byte strobes; both byte strobes replicate in[7:0].
    function automatic logic [WORD_W-1:0] merge_write(
        input logic [WORD_W-1:0] cur,
        input logic [WORD_W-1:0] din,
        input wr_strb_t          strb
    );
        logic [WORD_W-1:0] r;
        r = cur;
        if (strb.full) begin
            r = din;
        end else begin
            if (strb.up) r[15:8] = din[7:0];
            if (strb.lo) r[7:0]  = din[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pointer_reg.sv
// Architectural pointer register (PC/SP): load beats inc/dec, inc and dec
// together hold, arithmetic wraps modulo 2^WORD_W.
module pointer_reg
    import tiny16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_val_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [WORD_W-1:0] q_o
);

    localparam logic [WORD_W-1:0] ONE = 1;

    logic [WORD_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            ptr_d = ptr_q + ONE;
        end else if (dec_i && !inc_i) begin
            ptr_d = ptr_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= RESET_VAL;
        else     ptr_q <= ptr_d;
    end

    assign q_o = ptr_q;

endmodule

// File: rtl/register_file.sv
// Sixteen-entry 16-bit register file with PC/SP counters, bus and ALU ports.
// Define REG_FILE_DEBUG_EN to add the dbg_sel/dbg_data third read port.
module register_file
    import tiny16_pkg::*;
#(
    parameter logic [WORD_W-1:0] SP_INIT = SP_RESET,
    parameter logic [WORD_W-1:0] PC_INIT = PC_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  reg_src_sel,
    input  logic [SEL_W-1:0]  reg_dst_sel,
    input  logic              reg_in_en,
    input  logic              reg_up_en,
    input  logic              reg_lo_en,
    input  logic              reg_out_en,
    input  logic              reg_pc_inc,
    input  logic              reg_sp_inc,
    input  logic              reg_sp_dec,
`ifdef REG_FILE_DEBUG_EN
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [WORD_W-1:0] dbg_data,
`endif
    output logic [WORD_W-1:0] out,
    output logic [WORD_W-1:0] src_out,
    output logic [WORD_W-1:0] dst_out
);

    localparam int GPR_LO = int'(REG_BA);
    localparam int GPR_HI = int'(REG_RES);

    logic [WORD_W-1:0] pc_val, sp_val;
    logic [WORD_W-1:0] gpr_q [GPR_LO:GPR_HI];
    logic [WORD_W-1:0] gpr_d [GPR_LO:GPR_HI];
    logic [WORD_W-1:0] rd_vec [16];

    wr_strb_t          strb;
    logic              wr_any;
    logic [WORD_W-1:0] wr_val;
    logic              pc_load, sp_load;

    // Flat read view of committed state; R0 is hardwired to zero.
    always_comb begin
        rd_vec[0]      = '0;
        rd_vec[REG_PC] = pc_val;
        rd_vec[REG_SP] = sp_val;
        for (int i = GPR_LO; i <= GPR_HI; i++) begin
            rd_vec[i] = gpr_q[i];
        end
    end

    assign strb    = '{full: reg_in_en, up: reg_up_en, lo: reg_lo_en};
    assign wr_any  = reg_in_en | reg_up_en | reg_lo_en;
    assign wr_val  = merge_write(rd_vec[reg_dst_sel], in, strb);
    assign pc_load = wr_any && (reg_dst_sel == REG_PC);
    assign sp_load = wr_any && (reg_dst_sel == REG_SP);

    pointer_reg #(.RESET_VAL(PC_INIT)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pc_load),
        .load_val_i(wr_val),
        .inc_i     (reg_pc_inc),
        .dec_i     (1'b0),
        .q_o       (pc_val)
    );

    pointer_reg #(.RESET_VAL(SP_INIT)) u_sp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (sp_load),
        .load_val_i(wr_val),
        .inc_i     (reg_sp_inc),
        .dec_i     (reg_sp_dec),
        .q_o       (sp_val)
    );

    always_comb begin
        for (int i = GPR_LO; i <= GPR_HI; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (wr_any && (reg_dst_sel >= REG_BA)) begin
            gpr_d[reg_dst_sel] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = GPR_LO; i <= GPR_HI; i++) begin
            if (rst) gpr_q[i] <= '0;
            else     gpr_q[i] <= gpr_d[i];
        end
    end

    assign out     = reg_out_en ? rd_vec[reg_src_sel] : '0;
    assign src_out = rd_vec[reg_src_sel];
    assign dst_out = rd_vec[reg_dst_sel];

`ifdef REG_FILE_DEBUG_EN
    assign dbg_data = rd_vec[dbg_sel];
`else
    // Debug read port not built.
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected register contents are queued
// as stimulus is applied and drained through the bus/ALU read ports.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [3:0]  reg_src_sel, reg_dst_sel;
    logic        reg_in_en, reg_up_en, reg_lo_en, reg_out_en;
    logic        reg_pc_inc, reg_sp_inc, reg_sp_dec;
    logic [15:0] out, src_out, dst_out;
`ifdef REG_FILE_DEBUG_EN
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .reg_src_sel(reg_src_sel),
        .reg_dst_sel(reg_dst_sel),
        .reg_in_en  (reg_in_en),
        .reg_up_en  (reg_up_en),
        .reg_lo_en  (reg_lo_en),
        .reg_out_en (reg_out_en),
        .reg_pc_inc (reg_pc_inc),
        .reg_sp_inc (reg_sp_inc),
        .reg_sp_dec (reg_sp_dec),
`ifdef REG_FILE_DEBUG_EN
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
`endif
        .out        (out),
        .src_out    (src_out),
        .dst_out    (dst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in = '0;
        reg_in_en = 0; reg_up_en = 0; reg_lo_en = 0; reg_out_en = 0;
        reg_pc_inc = 0; reg_sp_inc = 0; reg_sp_dec = 0;
    endtask

    // Strobes are set by the caller just after a falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        idle();
    endtask

    task automatic wr(input logic [3:0] dst, input logic [15:0] d);
        reg_dst_sel = dst; in = d; reg_in_en = 1;
        tick();
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] sel, input logic [15:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reg_src_sel = e.sel; reg_dst_sel = e.sel; reg_out_en = 1;
            #2;
            chk({e.tag, "_out"}, out, e.val);
            chk({e.tag, "_src"}, src_out, e.val);
            chk({e.tag, "_dst"}, dst_out, e.val);
            @(negedge clk);
            reg_out_en = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reg_src_sel = 0; reg_dst_sel = 0;
`ifdef REG_FILE_DEBUG_EN
        dbg_sel = 0;
`endif
        rst = 1;
        @(negedge clk);
        tick();

        // Reset contents and disabled bus drive.
        reg_src_sel = 4'd2; #2;
        chk("rst_out_dis", out, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            expect_reg($sformatf("rst_r%0d", i), 4'(i), (i == 2) ? 16'hFFFF : 16'h0000);
        end
        drain();

        // Byte loads and discarded R0 writes.
        reg_dst_sel = 5; in = 16'h00AB; reg_lo_en = 1; tick();
        reg_dst_sel = 5; in = 16'h00CD; reg_up_en = 1; tick();
        wr(4'd0, 16'h1234);
        reg_dst_sel = 0; in = 16'h0055; reg_up_en = 1; reg_lo_en = 1; tick();
        reg_dst_sel = 8; in = 16'hAB77; reg_up_en = 1; reg_lo_en = 1; tick();
        expect_reg("byte_r5", 4'd5, 16'hCDAB);
        expect_reg("zero_r0", 4'd0, 16'h0000);
        expect_reg("both_r8", 4'd8, 16'h7777);
        drain();

        // PC wrap, write-over-increment, increment ignores dst.
        wr(4'd1, 16'hFFFF);
        reg_pc_inc = 1; tick();
        expect_reg("pc_wrap", 4'd1, 16'h0000);
        drain();
        reg_pc_inc = 1; reg_dst_sel = 1; in = 16'h0040; reg_in_en = 1; tick();
        expect_reg("pc_ovr", 4'd1, 16'h0040);
        drain();
        reg_pc_inc = 1; reg_dst_sel = 6; tick();
        expect_reg("pc_inc", 4'd1, 16'h0041);
        expect_reg("pc_r6", 4'd6, 16'h0000);
        drain();

        // SP push/pop sequence.
        reg_sp_dec = 1; tick();
        expect_reg("sp_dec", 4'd2, 16'hFFFE); drain();
        reg_sp_inc = 1; tick();
        expect_reg("sp_inc", 4'd2, 16'hFFFF); drain();
        reg_sp_inc = 1; reg_sp_dec = 1; tick();
        expect_reg("sp_both", 4'd2, 16'hFFFF); drain();
        wr(4'd2, 16'h0000);
        reg_sp_dec = 1; reg_dst_sel = 5; tick();
        expect_reg("sp_wrap", 4'd2, 16'hFFFF);
        expect_reg("sp_r5", 4'd5, 16'hCDAB);
        drain();
        reg_sp_dec = 1; reg_dst_sel = 2; in = 16'h1000; reg_in_en = 1; tick();
        expect_reg("sp_ovr", 4'd2, 16'h1000); drain();

        // Bus and ALU operand ports; no write-to-read bypass.
        wr(4'd6, 16'h0007);
        wr(4'd7, 16'h0003);
        reg_src_sel = 7; reg_dst_sel = 6; reg_out_en = 1; #2;
        chk("bus_out", out, 16'h0003);
        chk("bus_src", src_out, 16'h0003);
        chk("bus_dst", dst_out, 16'h0007);
        in = 16'h0055; reg_in_en = 1; #1;
        chk("bus_old", dst_out, 16'h0007);
        @(posedge clk); #1;
        chk("bus_new", dst_out, 16'h0055);
        @(negedge clk); idle();
        #2;
        chk("bus_off", out, 16'h0000);
        @(negedge clk);

`ifdef REG_FILE_DEBUG_EN
        wr(4'd3, 16'h5A5A);
        dbg_sel = 3; #1;
        chk("dbg_ba", dbg_data, 16'h5A5A);
        dbg_sel = 0; #1;
        chk("dbg_r0", dbg_data, 16'h0000);
        @(negedge clk);
`endif

        // Reset overrides every same-edge strobe.
        rst = 1; reg_dst_sel = 3; in = 16'hBEEF; reg_in_en = 1;
        reg_sp_dec = 1; reg_pc_inc = 1;
        tick();
        expect_reg("mid_ba", 4'd3, 16'h0000);
        expect_reg("mid_sp", 4'd2, 16'hFFFF);
        expect_reg("mid_pc", 4'd1, 16'h0000);
        expect_reg("mid_r6", 4'd6, 16'h0000);
        drain();
`ifdef REG_FILE_DEBUG_EN
        dbg_sel = 3; #1;
        chk("dbg_mid", dbg_data, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
